retire_monitor: RTL
===================

# retire_monitor

Retire-side consumer of the pipelined core's debug trace stream (retire PC, instruction-valid, control-flow and redirect flags). It counts cycles, retired instructions, retired control instructions and EX-stage redirects. It buffers retired PCs in a FIFO and drains them through a ready/valid port to a downstream trace sink. Counters are read back through a registered select port for bench scoreboarding or memory-mapped exposure.

## Interface
- FIFO_DEPTH, 16, trace FIFO entries; power of two, at least 2
- CNT_W, 32, width of each event counter; 1 to 32
- i_clk  in  1  sole clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_insn_vld  in  1  a real (non-bubble) instruction retires this cycle
- i_pc  in  32  PC of the retiring instruction; meaningful only when i_insn_vld=1
- i_ctrl  in  1  retiring instruction is a branch, JAL or JALR
- i_mispred  in  1  EX-stage redirect pulse; not aligned with retire
- i_enable  in  1  counting and trace capture enable
- i_clear  in  1  synchronous clear of counters, FIFO and overflow flag
- i_rd_sel  in  2  counter select: 00 cycles, 01 retired, 10 ctrl, 11 mispred
- o_rd_data  out  32  registered selected counter, zero-extended from CNT_W
- o_trace_valid  out  1  FIFO head entry available
- o_trace_pc  out  32  PC at FIFO head
- i_trace_ready  in  1  sink accepts the head this cycle
- o_trace_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky: at least one retired PC was dropped

## Operation
- Counters wrap modulo 2^CNT_W. They never saturate.
- cycles: +1 on every cycle with i_enable=1.
- retired: +1 when i_enable & i_insn_vld.
- ctrl: +1 when i_enable & i_insn_vld & i_ctrl. i_ctrl is ignored when i_insn_vld=0.
- mispred: +1 when i_enable & i_mispred, independent of i_insn_vld.
- Push: i_enable & i_insn_vld writes i_pc into the FIFO.
- Pop: o_trace_valid & i_trace_ready.
- FIFO is circular, with read/write pointers one bit wider than the index. It is full when the indices are equal and the MSBs differ; it is empty when the pointers are equal.
- Push while full with no pop in the same cycle: the entry is dropped, o_overflow is set, and FIFO contents are unchanged.
- Push while full with a pop in the same cycle: both operations take effect and the level stays at FIFO_DEPTH.
- Push and pop together at any other level: both take effect and the level is unchanged.
- i_clear=1: all counters go to 0, the FIFO empties (pointers to 0) and o_overflow goes to 0. Clear has priority over every same-cycle event and push, so those events are lost.
- o_trace_valid = not empty. o_trace_pc = mem[rd_ptr], combinational from storage. There is no fall-through: a push into an empty FIFO becomes visible after the edge.
- i_enable=0 freezes the counters and blocks pushes. Pops continue.

## Timing
- Reset (i_reset low, asynchronous):
  - all counters = 0, pointers = 0
  - o_rd_data = 0, o_trace_valid = 0, o_trace_level = 0, o_overflow = 0
  - o_trace_pc is don't-care while o_trace_valid=0
- Counter latency: an event sampled at edge t updates the counter at edge t. o_rd_data shows the new value after edge t+1.
- o_rd_data at edge k registers the counter selected by i_rd_sel as it stood before edge k. An i_rd_sel change therefore appears one cycle later.
- Trace latency: i_pc pushed at edge t appears on o_trace_pc with o_trace_valid=1 after edge t, when the FIFO was empty.
- Handshake: o_trace_valid and o_trace_pc hold until a pop. Dropping o_trace_valid without a pop occurs only on i_clear or reset.
- o_trace_level and o_overflow update on the same edge as the push or pop that changes them.
- Reset asserted mid-stream discards all state immediately. After deassertion, operation resumes on the first rising edge.

## Test plan
- Reset, then 10 cycles with i_enable=1 and no events, then i_rd_sel=00: o_rd_data=10 one cycle after the select. Retired, ctrl and mispred all read 0.
- Retire 5 PCs 0x0,0x4,0x8,0xC,0x10 (0x8 with i_ctrl=1) plus one i_mispred pulse with i_insn_vld=0:
  - retired=5, ctrl=1, mispred=1
  - with i_trace_ready=1, the sink receives the PCs in order; level returns to 0
- i_trace_ready=0 and FIFO_DEPTH+2 retirements:
  - level=FIFO_DEPTH, o_overflow=1
  - draining yields exactly the first FIFO_DEPTH PCs
- FIFO full, with push and pop in the same cycle: level stays FIFO_DEPTH, o_overflow stays 0, and the new PC is the last entry out.
- i_clear asserted in the same cycle as a retire and an i_mispred pulse: every counter reads 0, o_trace_valid=0 and o_overflow=0 on the next cycle.
- i_reset asserted asynchronously between edges with the FIFO half full: o_trace_valid=0, o_rd_data=0 and o_trace_level=0 immediately, before the next edge.

Source files
------------

// File: rtl/retire_monitor.sv
// Retire-side trace monitor: event counters with registered readback and a
// retired-PC FIFO drained through a ready/valid port.
module retire_monitor #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_insn_vld,
  input  logic [31:0]                   i_pc,
  input  logic                          i_ctrl,
  input  logic                          i_mispred,
  input  logic                          i_enable,
  input  logic                          i_clear,
  input  logic [1:0]                    i_rd_sel,
  output logic [31:0]                   o_rd_data,
  output logic                          o_trace_valid,
  output logic [31:0]                   o_trace_pc,
  input  logic                          i_trace_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_trace_level,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);

  logic [CNT_W-1:0] cnt_cycles, cnt_retired, cnt_ctrl, cnt_mispred;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [31:0]      mem [FIFO_DEPTH];
  logic             empty, full, push_req, pop, push, drop;
  logic [31:0]      sel_val;

  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push_req = i_enable && i_insn_vld;
    pop      = !empty && i_trace_ready;
    // A pop frees the head slot this edge, so a push into a full FIFO still lands.
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  always_comb begin
    sel_val = '0;
    case (i_rd_sel)
      2'd0: sel_val[CNT_W-1:0] = cnt_cycles;
      2'd1: sel_val[CNT_W-1:0] = cnt_retired;
      2'd2: sel_val[CNT_W-1:0] = cnt_ctrl;
      default: sel_val[CNT_W-1:0] = cnt_mispred;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_cycles  <= '0;
      cnt_retired <= '0;
      cnt_ctrl    <= '0;
      cnt_mispred <= '0;
    end else if (i_clear) begin
      cnt_cycles  <= '0;
      cnt_retired <= '0;
      cnt_ctrl    <= '0;
      cnt_mispred <= '0;
    end else if (i_enable) begin
      cnt_cycles <= cnt_cycles + CNT_ONE;
      if (i_insn_vld)           cnt_retired <= cnt_retired + CNT_ONE;
      if (i_insn_vld && i_ctrl) cnt_ctrl    <= cnt_ctrl + CNT_ONE;
      if (i_mispred)            cnt_mispred <= cnt_mispred + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) o_rd_data <= '0;
    else          o_rd_data <= sel_val;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr     <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr     <= rd_ptr + PTR_ONE;
      if (drop) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_clear) mem[wr_ptr[AW-1:0]] <= i_pc;
  end

  assign o_trace_valid = !empty;
  assign o_trace_pc    = mem[rd_ptr[AW-1:0]];
  assign o_trace_level = wr_ptr - rd_ptr;

endmodule
